jk_drive_seq: RTL and testbench

Excitation sequencer that drives a bank of JK flip-flops (j/k pairs, HOLD/RESET/SET/TOGGLE encoding) toward a requested target word. It accepts a target over a valid/ready handshake, computes per-bit J/K excitation against the bank's Q readback, and applies it for one cycle. After a settle window it verifies the readback, retrying up to a bound, then reports done or error. It sits on the control side of the flop bank: the bank responds, this block initiates.

---
 rtl/jk_drive_seq_pkg.sv | 23 ++
 rtl/jk_drive_seq_if.sv | 26 ++
 rtl/jk_drive_seq_excite.sv | 33 +++
 rtl/jk_drive_seq.sv | 111 +++++++++++
 tb/tb_jk_drive_seq.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/jk_drive_seq_pkg.sv
// Shared types for the JK drive sequencer: per-bit excitation modes and FSM states.
package jk_pkg;

  typedef enum logic [1:0] {
    HOLD   = 2'd0,
    RESET  = 2'd1,
    SET    = 2'd2,
    TOGGLE = 2'd3
  } jk_mode_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SETTLE = 2'd2,
    CHECK  = 2'd3
  } jk_drive_state_t;

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/jk_drive_seq_if.sv
// Target handshake plus flop-bank drive/readback bundle for jk_drive_seq.
interface jk_drive_seq_if #(
  parameter int WIDTH = 8,
  parameter int RW    = 2
);
  logic             tgt_valid;
  logic             tgt_ready;
  logic [WIDTH-1:0] tgt_data;
  logic [WIDTH-1:0] q_fb;
  logic [WIDTH-1:0] j_o;
  logic [WIDTH-1:0] k_o;
  logic             busy;
  logic             done;
  logic             err;
  logic [RW-1:0]    retries;

  modport master (
    output tgt_valid, tgt_data, q_fb,
    input  tgt_ready, j_o, k_o, busy, done, err, retries
  );

  modport slave (
    input  tgt_valid, tgt_data, q_fb,
    output tgt_ready, j_o, k_o, busy, done, err, retries
  );
endinterface

// File: rtl/jk_drive_seq_excite.sv
// Combinational per-word JK excitation from current Q toward a target.
// JK_DRIVE_TOGGLE_EN selects TOGGLE instead of SET/RESET for mismatched bits.
module jk_excite
  import jk_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] tgt_i,
  output logic [WIDTH-1:0] j_o,
  output logic [WIDTH-1:0] k_o
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    jk_mode_t mode_s;

    always_comb begin
      mode_s = HOLD;
      if (q_i[i] != tgt_i[i]) begin
`ifdef JK_DRIVE_TOGGLE_EN
        mode_s = TOGGLE;
`else
        mode_s = tgt_i[i] ? SET : RESET;
`endif
      end else begin
        mode_s = HOLD;
      end
    end

    assign {j_o[i], k_o[i]} = mode_s;
  end

endmodule

// File: rtl/jk_drive_seq.sv
// Drives a JK flop bank toward a requested word, verifies readback, retries.
// Build option: JK_DRIVE_TOGGLE_EN (mismatched bits driven TOGGLE).
module jk_drive_seq
  import jk_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int MAX_RETRY  = 3,
  parameter int SETTLE_CYC = 1
) (
  input logic          clk,
  input logic          rst,
  jk_drive_seq_if.slave bus
);

  localparam int RW = cnt_width(MAX_RETRY + 1);
  localparam int SW = cnt_width(SETTLE_CYC);

  jk_drive_state_t  state_q, state_d;
  logic [WIDTH-1:0] tgt_q, tgt_d;
  logic [RW-1:0]    retries_q, retries_d;
  logic [SW-1:0]    settle_q, settle_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             drive_en_s;
  logic [WIDTH-1:0] exc_j_s, exc_k_s;

  jk_excite #(.WIDTH(WIDTH)) u_excite (
    .q_i   (bus.q_fb),
    .tgt_i (tgt_q),
    .j_o   (exc_j_s),
    .k_o   (exc_k_s)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      tgt_q     <= '0;
      retries_q <= '0;
      settle_q  <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tgt_q     <= tgt_d;
      retries_q <= retries_d;
      settle_q  <= settle_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // Next-state and drive-enable decode.
  always_comb begin
    state_d    = state_q;
    tgt_d      = tgt_q;
    retries_d  = retries_q;
    settle_d   = settle_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    drive_en_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.tgt_valid) begin
          tgt_d     = bus.tgt_data;
          retries_d = '0;
          state_d   = DRIVE;
        end else begin
          state_d = IDLE;
        end
      end
      DRIVE: begin
        drive_en_s = 1'b1;
        settle_d   = '0;
        state_d    = SETTLE;
      end
      SETTLE: begin
        if (settle_q == SW'(SETTLE_CYC - 1)) begin
          state_d = CHECK;
        end else begin
          settle_d = settle_q + SW'(1);
        end
      end
      CHECK: begin
        if (bus.q_fb == tgt_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (retries_q < RW'(MAX_RETRY)) begin
          retries_d = retries_q + RW'(1);
          state_d   = DRIVE;
        end else begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Drive is masked by reset without waiting for the clock edge.
  assign bus.j_o       = (drive_en_s && !rst) ? exc_j_s : '0;
  assign bus.k_o       = (drive_en_s && !rst) ? exc_k_s : '0;
  assign bus.tgt_ready = (state_q == IDLE) && !rst;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.retries   = retries_q;

endmodule

// File: tb/tb_jk_drive_seq.sv
// Scoreboard bench for jk_drive_seq with a JK flop bank model and stuck-at faults.
module tb_jk_drive_seq;
  import jk_pkg::*;

  localparam int W   = 8;
  localparam int MR  = 3;
  localparam int SC  = 1;
  localparam int RW  = cnt_width(MR + 1);
  localparam int LAT = 2 + SC;

  typedef struct {
    bit            is_err;
    logic [RW-1:0] retries;
    logic [W-1:0]  final_q;
    int            lat;
    int            drives;
    int            acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  jk_drive_seq_if #(.WIDTH(W), .RW(RW)) bus ();

  jk_drive_seq #(.WIDTH(W), .MAX_RETRY(MR), .SETTLE_CYC(SC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [W-1:0] bank_q, stuck0, load_val;
  logic         load_en;
  exp_t         sb[$];
  int           checks = 0, failures = 0, cyc = 0, drv_cnt = 0;

  function automatic logic [W-1:0] jk_next(input logic [W-1:0] q, j, k);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) begin
      case ({j[i], k[i]})
        2'b00:   r[i] = q[i];
        2'b01:   r[i] = 1'b0;
        2'b10:   r[i] = 1'b1;
        default: r[i] = ~q[i];
      endcase
    end
    return r;
  endfunction

  // Flop bank: loadable by the bench, otherwise a JK register with stuck-at-0 bits.
  always @(posedge clk) begin
    if (load_en) bank_q <= load_val & ~stuck0;
    else         bank_q <= jk_next(bank_q, bus.j_o, bus.k_o) & ~stuck0;
  end
  assign bus.q_fb = bank_q;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] exp_drive(input logic [W-1:0] q, t);
`ifdef JK_DRIVE_TOGGLE_EN
    return 32'({q ^ t, q ^ t});
`else
    return 32'({t & ~q, q & ~t});
`endif
  endfunction

  // Each attempt lands every non-stuck bit on target; success once Q equals target.
  function automatic exp_t model(input logic [W-1:0] q0, t, stuck);
    exp_t         e;
    logic [W-1:0] q = q0;
    e.drives = 0;
    for (int a = 0; a <= MR; a++) begin
      if (q != t) e.drives++;
      q = t & ~stuck;
      if (q == t) begin
        e.is_err = 1'b0; e.retries = RW'(a); e.final_q = q; e.lat = (a + 1) * LAT;
        return e;
      end
    end
    e.is_err = 1'b1; e.retries = RW'(MR); e.final_q = q; e.lat = (MR + 1) * LAT;
    return e;
  endfunction

  // Monitor: pops the scoreboard whenever done or err is presented.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      drv_cnt = 0;
    end else begin
      if ((bus.j_o | bus.k_o) != '0) drv_cnt++;
      if (bus.busy) check("ready_low_while_busy", 32'(bus.tgt_ready), 32'd0);
      if (bus.done || bus.err) begin
        if (sb.size() == 0) begin
          check("unexpected_pulse", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("pulse_kind_err", 32'(bus.err), 32'(e.is_err));
          check("pulse_kind_done", 32'(bus.done), 32'(!e.is_err));
          check("retries", 32'(bus.retries), 32'(e.retries));
          check("final_q", 32'(bus.q_fb), 32'(e.final_q));
          check("latency", 32'(cyc - e.acc), 32'(e.lat));
          check("drive_cycles", 32'(drv_cnt), 32'(e.drives));
        end
        drv_cnt = 0;
      end
    end
  end

  task automatic set_bank(input logic [W-1:0] v, input logic [W-1:0] stuck);
    @(negedge clk);
    stuck0 = stuck; load_val = v; load_en = 1'b1;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  task automatic send(input logic [W-1:0] t, input bit keep);
    exp_t         e;
    logic [W-1:0] q_at;
    int           n = 0;
    @(negedge clk);
    bus.tgt_valid = 1'b1;
    bus.tgt_data  = t;
    while (!bus.tgt_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.tgt_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      bus.tgt_valid = 1'b0;
      return;
    end
    q_at  = bank_q;
    e     = model(q_at, t, stuck0);
    e.acc = cyc + 1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check("drive_jk", 32'({bus.j_o, bus.k_o}), exp_drive(q_at, t));
    if (!keep) bus.tgt_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((sb.size() != 0 || bus.busy) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      check("drain_timeout", 32'd0, 32'd1);
      sb.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    bus.tgt_valid = 1'b0;
    bus.tgt_data  = '0;
    stuck0 = '0; load_val = '0; load_en = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(bus.tgt_ready), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done_err", 32'({bus.done, bus.err}), 32'd0);
    check("rst_retries", 32'(bus.retries), 32'd0);
    check("rst_jk", 32'({bus.j_o, bus.k_o}), 32'd0);
    rst = 1'b0; load_en = 1'b0;
    #1;
    check("ready_after_rst", 32'(bus.tgt_ready), 32'd1);

    set_bank(8'h00, 8'h00); send(8'hA5, 1'b0); wait_idle();
    set_bank(8'hF0, 8'h00); send(8'h0F, 1'b0); wait_idle();
    set_bank(8'h00, 8'h01); send(8'h01, 1'b0); wait_idle();

    set_bank(8'h00, 8'h00);
    send(8'h3C, 1'b1);
    send(8'hC3, 1'b0);
    wait_idle();
    check("b2b_final_q", 32'(bank_q), 32'h0000_00C3);

    // Reset while DRIVE is active: drive must vanish in the same cycle.
    set_bank(8'h00, 8'h00);
    send(8'hFF, 1'b0);
    rst = 1'b1;
    #1;
    check("rst_masks_drive", 32'({bus.j_o, bus.k_o}), 32'd0);
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("drive_rst_idle", 32'({bus.tgt_ready, bus.busy}), 32'h2);

    // Reset during SETTLE abandons the transaction silently.
    set_bank(8'h00, 8'h00);
    send(8'hAA, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("settle_rst_jk", 32'({bus.j_o, bus.k_o}), 32'd0);
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("settle_rst_state", 32'({bus.tgt_ready, bus.busy, bus.done, bus.err}), 32'h8);
    repeat (6) begin
      @(negedge clk);
      check("no_pulse_after_rst", 32'({bus.done, bus.err}), 32'd0);
    end
    send(8'h55, 1'b0); wait_idle();

    repeat (30) begin
      logic [W-1:0] stk;
      stk = ($urandom_range(0, 3) == 0) ? W'(1 << $urandom_range(0, W - 1)) : '0;
      set_bank(W'($urandom), stk);
      send(W'($urandom), 1'b0);
      wait_idle();
    end

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
